serial_pattern_gen: RTL

Upstream stimulus stage for the serial sequence detectors. It captures a WIDTH-bit pattern from the board switches and presents it one bit at a time, MSB first, on a registered serial output. Each bit is accompanied by a one-cycle advance strobe that the detector's state memory consumes as its enable. Bits advance either on a manual step pulse or on an internal divided tick.

---
 rtl/serial_pattern_gen.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/serial_pattern_gen.sv
// Captures a WIDTH-bit switch pattern and emits it MSB first with a one-cycle advance strobe.
// Optional SERIAL_GEN_LOOP_EN: repeat the captured pattern indefinitely instead of stopping in DONE.
module serial_pattern_gen #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [WIDTH-1:0]         pattern,
  input  logic                     run,
  input  logic                     step,
  output logic                     X,
  output logic                     X_valid,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SHIFT, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_shreg;
  logic [CNT_W-1:0]   r_cnt;
  logic [DIV_W-1:0]   r_div;
  logic               r_x;
  logic               r_xv;
  logic [IDX_W-1:0]   r_idx;
  logic               r_busy;
  logic               r_done;
`ifdef SERIAL_GEN_LOOP_EN
  logic [WIDTH-1:0]   r_copy;
`endif

  logic w_active;
  logic w_tick;
  logic w_adv;
  logic w_load;
  logic w_last;

  assign w_active = (r_state == S_ARMED) || (r_state == S_SHIFT);
  assign w_tick   = w_active && run && (r_div == DIV_LAST);
  // Only the source selected by run may advance; the other is dropped.
  assign w_adv    = w_active && (run ? w_tick : step);
  assign w_load   = ((r_state == S_IDLE) || (r_state == S_DONE)) && load;
  assign w_last   = w_adv && (r_cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (load) w_state_nxt = S_ARMED;
      end
      S_ARMED, S_SHIFT: begin
        if (w_adv) begin
`ifdef SERIAL_GEN_LOOP_EN
          w_state_nxt = S_SHIFT;
`else
          w_state_nxt = w_last ? S_DONE : S_SHIFT;
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_div   <= '0;
      r_x     <= 1'b0;
      r_xv    <= 1'b0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_GEN_LOOP_EN
      r_copy  <= '0;
`endif
    end else begin
      r_xv <= w_adv;

      // Divider runs only while shifting in run mode; leaving run mode restarts the period.
      if (w_active && run) begin
        r_div <= w_tick ? '0 : r_div + DIV_W'(1);
      end else begin
        r_div <= '0;
      end

      if (w_load) begin
        r_shreg <= pattern;
        r_cnt   <= CNT_W'(WIDTH);
`ifdef SERIAL_GEN_LOOP_EN
        r_copy  <= pattern;
`endif
      end else if (w_adv) begin
        r_x   <= r_shreg[WIDTH-1];
        r_idx <= IDX_W'(r_cnt - CNT_W'(1));
`ifdef SERIAL_GEN_LOOP_EN
        if (w_last) begin
          r_shreg <= r_copy;
          r_cnt   <= CNT_W'(WIDTH);
        end else begin
          r_shreg <= r_shreg << 1;
          r_cnt   <= r_cnt - CNT_W'(1);
        end
`else
        r_shreg <= r_shreg << 1;
        r_cnt   <= r_cnt - CNT_W'(1);
`endif
      end

      r_busy <= (w_state_nxt == S_ARMED) || (w_state_nxt == S_SHIFT);
`ifdef SERIAL_GEN_LOOP_EN
      r_done <= w_last;
`else
      r_done <= (w_state_nxt == S_DONE);
`endif
    end
  end

  assign X       = r_x;
  assign X_valid = r_xv;
  assign bit_idx = r_idx;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule
